// File: rtl/booth_word_mul_seq_pkg.sv
// Shared constants for the RSA Montgomery multiplier datapath: widths, FSM state
// encodings and the radix-4 Booth digit decoder.
package rsa_mul_pkg;

    localparam int WORD_WIDTH      = 16;
    localparam int NUMBER_REAL_BIT = WORD_WIDTH + 2;
    localparam int CSA_WIDTH       = 32;
    localparam int N_PP            = 9;
    localparam int N_SIGN          = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_ACCUM  = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_LAST   = 3'd4;

    localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
    localparam logic [2:0] BOOTH_P1_A   = 3'b001;
    localparam logic [2:0] BOOTH_P1_B   = 3'b010;
    localparam logic [2:0] BOOTH_P2     = 3'b011;
    localparam logic [2:0] BOOTH_M2     = 3'b100;
    localparam logic [2:0] BOOTH_M1_A   = 3'b101;
    localparam logic [2:0] BOOTH_M1_B   = 3'b110;
    localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

    typedef enum logic [1:0] {
        MAG_ZERO = 2'd0,
        MAG_ONE  = 2'd1,
        MAG_TWO  = 2'd2
    } booth_mag_e;

    typedef struct packed {
        logic       neg;
        booth_mag_e mag;
    } booth_digit_t;

    function automatic booth_digit_t booth_decode(input logic [2:0] code);
        booth_digit_t d;
        d.neg = 1'b0;
        d.mag = MAG_ZERO;
        case (code)
            BOOTH_P1_A, BOOTH_P1_B: d.mag = MAG_ONE;
            BOOTH_P2:               d.mag = MAG_TWO;
            BOOTH_M2:               begin d.neg = 1'b1; d.mag = MAG_TWO; end
            BOOTH_M1_A, BOOTH_M1_B: begin d.neg = 1'b1; d.mag = MAG_ONE; end
            default:                d.mag = MAG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_word_mul_seq_if.sv
// Host-side request / result-stream bundle of the word-serial multiplier.
interface booth_word_mul_seq_if #(
    parameter int WORDS = 4
);
    logic                  start;
    logic [WORDS*16-1:0]   a_in;
    logic [15:0]           b_in;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
    logic                  out_last;

    modport master (
        output start, a_in, b_in, out_ready,
        input  busy, out_valid, out_data, out_last
    );

    modport slave (
        input  start, a_in, b_in, out_ready,
        output busy, out_valid, out_data, out_last
    );
endinterface

// File: rtl/booth_word_mul_seq_enc.sv
// Radix-4 Booth encoder for one digit: 3-bit code and 16-bit word give an 18-bit
// two's-complement partial product plus its sign flag.
module booth_r4_enc
    import rsa_mul_pkg::*;
(
    input  logic [2:0]                 code_i,
    input  logic [WORD_WIDTH-1:0]      word_i,
    output logic [NUMBER_REAL_BIT-1:0] pp_o,
    output logic                       neg_o
);

    booth_digit_t               digit;
    logic [NUMBER_REAL_BIT-1:0] mag;

    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        digit = booth_decode(code_i);
        mag   = '0;
        case (digit.mag)
            MAG_ONE: mag = {2'b00, word_i};
            MAG_TWO: mag = {1'b0, word_i, 1'b0};
            default: mag = '0;
        endcase
        pp_o  = digit.neg ? (~mag + {{(NUMBER_REAL_BIT-1){1'b0}}, 1'b1}) : mag;
        neg_o = digit.neg;
    end

endmodule

// File: rtl/booth_word_mul_seq.sv
// Word-serial A*b sequencer: Booth-encodes b against one word of A per pass, feeds the
// external 9:2 compressor, folds in the running carry word and streams WORDS+1 words out.
module booth_word_mul_seq
    import rsa_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WORDS      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    booth_word_mul_seq_if.slave             host,
    output logic [N_PP*NUMBER_REAL_BIT-1:0] csa_data,
    output logic                            csa_flag_zero,
    output logic [N_SIGN-1:0]               csa_shift_direct,
    input  logic [CSA_WIDTH-1:0]            csa_sum,
    input  logic [CSA_WIDTH-1:0]            csa_carry
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int A_W   = WORDS * DATA_WIDTH;
    localparam int PP_W  = N_PP * NUMBER_REAL_BIT;

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH:0]     hi_q, hi_d;
    logic [A_W-1:0]          a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [CSA_WIDTH-1:0]    p_q, p_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic [PP_W-1:0]         csa_data_q, csa_data_d;
    logic                    flag_q, flag_d;
    logic [N_SIGN-1:0]       shift_q, shift_d;

    logic [DATA_WIDTH-1:0]   enc_a, enc_b;
    logic [DATA_WIDTH+2:0]   b_ext;
    logic [PP_W-1:0]         pp_all;
    logic [N_PP-1:0]         neg;
    logic [N_SIGN-1:0]       shift_next;
    logic [CSA_WIDTH:0]      acc_sum;
    logic                    unused_bits;

    // a_q holds only the words not yet issued, so the next word is always its LSW.
    always_comb begin
        enc_a = a_q[DATA_WIDTH-1:0];
        enc_b = b_q;
        if (state_q == ST_IDLE) begin
            enc_a = host.a_in[DATA_WIDTH-1:0];
            enc_b = host.b_in;
        end
    end

    assign b_ext = {2'b00, enc_b, 1'b0};

    for (genvar k = 0; k < N_PP; k++) begin : g_enc
        booth_r4_enc u_enc (
            .code_i (b_ext[2*k +: 3]),
            .word_i (enc_a),
            .pp_o   (pp_all[k*NUMBER_REAL_BIT +: NUMBER_REAL_BIT]),
            .neg_o  (neg[k])
        );
    end

    // A zero word must never be sign-extended, even under a negative digit.
    assign shift_next  = neg[N_SIGN-1:0] & {N_SIGN{|enc_a}};
    assign acc_sum     = {1'b0, p_q} + {{(CSA_WIDTH-DATA_WIDTH){1'b0}}, hi_q};
    assign unused_bits = csa_carry[CSA_WIDTH-1] ^ (|neg[N_PP-1:N_SIGN]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        csa_data_d  = csa_data_q;
        flag_d      = 1'b0;
        shift_d     = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    a_d        = A_W'(host.a_in >> DATA_WIDTH);
                    b_d        = host.b_in;
                    idx_d      = '0;
                    hi_d       = '0;
                    csa_data_d = pp_all;
                    shift_d    = shift_next;
                    flag_d     = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                p_d     = csa_sum + {csa_carry[CSA_WIDTH-2:0], 1'b0};
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                out_data_d  = acc_sum[DATA_WIDTH-1:0];
                hi_d        = acc_sum[CSA_WIDTH:DATA_WIDTH];
                out_valid_d = 1'b1;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (host.out_ready) begin
                    if (idx_q == IDX_W'(WORDS-1)) begin
                        out_data_d = hi_q[DATA_WIDTH-1:0];
                        out_last_d = 1'b1;
                        state_d    = ST_LAST;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        a_d         = a_q >> DATA_WIDTH;
                        csa_data_d  = pp_all;
                        shift_d     = shift_next;
                        flag_d      = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_LAST: begin
                if (host.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hi_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            csa_data_q  <= '0;
            flag_q      <= 1'b0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            csa_data_q  <= csa_data_d;
            flag_q      <= flag_d;
            shift_q     <= shift_d;
        end
    end

    assign host.busy        = busy_q;
    assign host.out_valid   = out_valid_q;
    assign host.out_data    = out_data_q;
    assign host.out_last    = out_last_q;
    assign csa_data         = csa_data_q;
    assign csa_flag_zero    = flag_q;
    assign csa_shift_direct = shift_q;

endmodule

// File: tb/tb_booth_word_mul_seq.sv
// Self-checking bench for booth_word_mul_seq with a behavioural 9:2 compressor that
// splits the true partial-product sum into a Sum/Carry pair.
module tb_booth_word_mul_seq;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [161:0]  csa_data;
    logic          csa_flag_zero;
    logic [6:0]    csa_shift_direct;
    logic [31:0]   csa_sum, csa_carry;
    logic [31:0]   carry_seed = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    booth_word_mul_seq_if #(.WORDS(4)) host();

    booth_word_mul_seq #(.DATA_WIDTH(16), .WORDS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .host             (host),
        .csa_data         (csa_data),
        .csa_flag_zero    (csa_flag_zero),
        .csa_shift_direct (csa_shift_direct),
        .csa_sum          (csa_sum),
        .csa_carry        (csa_carry)
    );

    always #5 clk = ~clk;

    // Compressor model: exact sum of shifted partial products, split with a random carry.
    logic [31:0] cmp_total, cmp_ext;
    logic [8:0]  cmp_sx;
    always_comb begin
        cmp_total = '0;
        cmp_ext   = '0;
        cmp_sx    = {2'b00, csa_shift_direct};
        if (csa_flag_zero) begin
            for (int k = 0; k < 9; k++) begin
                cmp_ext = {14'b0, csa_data[18*k +: 18]};
                if (cmp_sx[k]) cmp_ext[31:18] = {14{csa_data[18*k+17]}};
                cmp_total = cmp_total + (cmp_ext << (2*k));
            end
        end
        csa_carry = csa_flag_zero ? carry_seed : 32'h0;
        csa_sum   = cmp_total - {csa_carry[30:0], 1'b0};
    end

    task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_shift(input logic [15:0] aw, input logic [15:0] b);
        logic [18:0] e;
        logic [2:0]  c;
        logic [6:0]  m;
        e = {2'b00, b, 1'b0};
        m = '0;
        for (int k = 0; k < 7; k++) begin
            c = e[2*k +: 3];
            m[k] = (c == 3'b100) || (c == 3'b101) || (c == 3'b110);
        end
        return (aw == 16'h0) ? 7'h0 : m;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " busy"},      162'(host.busy),        162'(0));
        check({tag, " out_valid"}, 162'(host.out_valid),   162'(0));
        check({tag, " out_last"},  162'(host.out_last),    162'(0));
        check({tag, " out_data"},  162'(host.out_data),    162'(0));
        check({tag, " csa_data"},  csa_data,               162'(0));
        check({tag, " flag_zero"}, 162'(csa_flag_zero),    162'(0));
        check({tag, " shift"},     162'(csa_shift_direct), 162'(0));
    endtask

    // One full operation; optional stall at a given word and a start pulse while busy.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [15:0] b,
                          input logic [79:0] prod, input int ready_pct, input bit chk_time,
                          input int stall_word, input bit glitch);
        int          cyc;
        int          words;
        int          stall_left;
        logic [15:0] held;
        held = '0;
        host.a_in      = a;
        host.b_in      = b;
        host.start     = 1'b1;
        host.out_ready = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        cyc        = 1;
        words      = 0;
        stall_left = 5;
        check({tag, " busy after start"}, 162'(host.busy), 162'(1));
        while (words < 5 && cyc < 400) begin
            host.start = 1'b0;
            if (glitch && cyc == 4) begin
                host.start = 1'b1;
                host.a_in  = ~a;
                host.b_in  = ~b;
            end
            if (stall_word == words && host.out_valid && stall_left > 0) begin
                if (stall_left == 5) held = host.out_data;
                else begin
                    check({tag, " stall data"},  162'(host.out_data),  162'(held));
                    check({tag, " stall valid"}, 162'(host.out_valid), 162'(1));
                end
                check({tag, " stall flag_zero"}, 162'(csa_flag_zero), 162'(0));
                host.out_ready = 1'b0;
                stall_left--;
            end else if (ready_pct >= 100) begin
                host.out_ready = 1'b1;
            end else begin
                host.out_ready = ($urandom_range(99) < ready_pct);
            end
            if (csa_flag_zero)
                check($sformatf("%s shift w%0d", tag, words), 162'(csa_shift_direct),
                      162'(exp_shift(a[16*words +: 16], b)));
            if (host.out_valid && host.out_ready) begin
                check($sformatf("%s word%0d", tag, words), 162'(host.out_data),
                      162'(prod[16*words +: 16]));
                check($sformatf("%s last%0d", tag, words), 162'(host.out_last),
                      162'(words == 4));
                if (chk_time)
                    check($sformatf("%s time%0d", tag, words), 162'(cyc),
                          162'((words < 4) ? 3*words + 3 : 13));
                words++;
            end
            @(negedge clk);
            cyc++;
        end
        host.start     = 1'b0;
        host.out_ready = 1'b1;
        if (words < 5) begin
            check({tag, " words before timeout"}, 162'(words), 162'(5));
        end else begin
            check({tag, " busy at end"}, 162'(host.busy), 162'(0));
            if (chk_time) check({tag, " busy-low cycle"}, 162'(cyc), 162'(14));
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [15:0] b;
        logic [79:0] prod;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] ra;
    logic [15:0] rb;
    int          seen;

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 80'hFFFE_FFFF_FFFF_FFFF_0001};
        vecs[1] = '{64'h0000_1234_0000_0001, 16'hAAAA, 80'h0000_0C22_9E88_0000_AAAA};
        vecs[2] = '{64'h1357_9BDF_2468_ACE0, 16'h0000, 80'h0};
        vecs[3] = '{64'h0000_0000_0000_0001, 16'h0001, 80'h0000_0000_0000_0000_0001};
        vecs[4] = '{64'h0000_0000_0000_FFFF, 16'h8000, 80'h0000_0000_0000_7FFF_8000};
        vecs[5] = '{64'h8000_0000_0000_0000, 16'h0002, 80'h0001_0000_0000_0000_0000};
        vecs[6] = '{64'h0001_0001_0001_0001, 16'h1234, 80'h0000_1234_1234_1234_1234};
        vecs[7] = '{64'h0000_0000_0000_0002, 16'hFFFF, 80'h0000_0000_0000_0001_FFFE};

        host.start     = 1'b0;
        host.a_in      = '0;
        host.b_in      = '0;
        host.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            carry_seed = $urandom;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, 100, 1'b1, -1, 1'b0);
        end

        ra = {$urandom, $urandom};
        run_op("b0 random A", ra, 16'h0000, 80'h0, 100, 1'b1, -1, 1'b0);

        run_op("stall", vecs[1].a, vecs[1].b, vecs[1].prod, 100, 1'b0, 2, 1'b0);
        run_op("glitch start", vecs[0].a, vecs[0].b, vecs[0].prod, 100, 1'b1, -1, 1'b1);

        // Reset while word 2 is being presented, then a clean operation.
        host.a_in      = vecs[1].a;
        host.b_in      = vecs[1].b;
        host.start     = 1'b1;
        host.out_ready = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen < 2; c++) begin
            if (host.out_valid) seen++;
            @(negedge clk);
        end
        for (int c = 0; c < 10 && !host.out_valid; c++) @(negedge clk);
        check("mid-op word2 valid", 162'(host.out_valid), 162'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid-op reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after reset", vecs[7].a, vecs[7].b, vecs[7].prod, 100, 1'b1, -1, 1'b0);

        for (int r = 0; r < 1000; r++) begin
            ra         = {$urandom, $urandom};
            rb         = 16'($urandom);
            carry_seed = $urandom;
            run_op($sformatf("rand%0d", r), ra, rb, {16'h0, ra} * {64'h0, rb}, 70, 1'b0, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
